regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=2); AW = clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rs_addr  input  NRD*AW  read addresses; port k at bits [k*AW +: AW].
REQ-008 SHALL have port rs_data  output  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
REQ-009 SHALL have port rs_busy  output  NRD  per-port scoreboard hazard flag.
REQ-010 SHALL have ports wa_we/wa_addr/wa_data  input  1/AW/XLEN  write port A (ALU writeback).
REQ-011 SHALL have ports wb_we/wb_addr/wb_data  input  1/AW/XLEN  write port B (load writeback, clears busy).
REQ-012 SHALL have ports iss_valid/iss_rd  input  1/AW  issue of a long-latency op targeting iss_rd (sets busy).
REQ-013 SHALL have port busy_vec  output  NREG  current scoreboard state, bit i = register i busy.

Function
REQ-014 SHALL hold NREG x XLEN storage plus NREG-bit busy scoreboard.
REQ-015 Register 0 SHALL read as 0 always, ignore all writes, and never become busy.
REQ-016 Writes SHALL commit at rising clk when the port's we=1 and addr!=0.
REQ-017 Both ports writing the same nonzero address in one cycle: port B data SHALL win.
REQ-018 Reads SHALL be combinational from storage (zero latency).
REQ-019 BYPASS=1: if a read address matches an active nonzero write this cycle, rs_data SHALL return the write data (B priority over A); BYPASS=0: SHALL return stored value.
REQ-020 iss_valid=1 with iss_rd!=0 SHALL set busy[iss_rd] at the next edge.
REQ-021 wb_we=1 with wb_addr!=0 SHALL clear busy[wb_addr] at the next edge; port A SHALL not affect busy.
REQ-022 Issue and port-B writeback to the same register in one cycle: set SHALL win (busy stays 1).
REQ-023 rs_busy[k] SHALL be busy[rs_addr_k], forced 0 when rs_addr_k==0, and (BYPASS=1 only) forced 0 when wb_we=1 and wb_addr==rs_addr_k.
REQ-024 Issue to an already-busy register SHALL leave it busy (no counting; single outstanding producer per register).
REQ-025 busy_vec SHALL reflect registered scoreboard state only (no bypass terms).

Reset
REQ-026 rst=1 SHALL asynchronously clear all registers to 0 and all busy bits to 0, independent of clk.
REQ-027 While rst=1, rs_data SHALL read 0 for all addresses not bypassed, busy_vec=0, rs_busy=0; writes and issues SHALL be ignored.
REQ-028 Reset asserted mid-operation (pending busy, simultaneous write) SHALL discard the in-flight write and busy set.

Verification
REQ-029 Reset then read all addresses on every port -> rs_data=0, busy_vec=0.
REQ-030 wa_we=1, wa_addr=5, wa_data=0xDEADBEEF, rs_addr port0=5 same cycle -> BYPASS=1: 0xDEADBEEF immediately; BYPASS=0: 0 this cycle, 0xDEADBEEF next cycle.
REQ-031 wa and wb both write addr 7 (0x11111111 / 0x22222222) -> next cycle read 7 = 0x22222222.
REQ-032 wa_we=1, wa_addr=0, wa_data=0xFFFFFFFF; iss_valid=1, iss_rd=0 -> read 0 = 0, busy_vec[0]=0.
REQ-033 iss_rd=3 -> busy_vec=0x00000008, rs_busy=1 for port reading 3; two cycles later wb writes 3 with 0xABCD -> rs_busy=0 that cycle (BYPASS=1), busy_vec=0 next edge; same-cycle iss_rd=3 + wb 3 -> busy stays 1.
REQ-034 Write 0x55 to reg 9, set busy[9], assert rst between edges -> read 9 = 0 and busy_vec=0 before next clk edge.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file with a busy scoreboard for long-latency producers.
// Register 0 reads as zero; write port B wins collisions and also retires busy bits.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                wa_we,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_we,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;

    logic w_wa_act;
    logic w_wb_act;
    logic w_iss_act;

    assign w_wa_act  = wa_we && (wa_addr != '0);
    assign w_wb_act  = wb_we && (wb_addr != '0);
    assign w_iss_act = iss_valid && (iss_rd != '0);

    // Port B is applied after port A so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wa_act) begin
                r_regs[wa_addr] <= wa_data;
            end
            if (w_wb_act) begin
                r_regs[wb_addr] <= wb_data;
            end
        end
    end

    // Set after clear: a new issue outranks the retiring load on the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (w_wb_act) begin
                r_busy[wb_addr] <= 1'b0;
            end
            if (w_iss_act) begin
                r_busy[iss_rd] <= 1'b1;
            end
        end
    end

    assign busy_vec = r_busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_wb_hit;
        logic            w_wa_hit;

        assign w_addr   = rs_addr[k*AW +: AW];
        assign w_wb_hit = (BYPASS != 0) && w_wb_act && (wb_addr == w_addr);
        assign w_wa_hit = (BYPASS != 0) && w_wa_act && (wa_addr == w_addr);

        always_comb begin
            w_data = '0;
            if (w_addr != '0) begin
                w_data = r_regs[w_addr];
            end
            if (w_wb_hit) begin
                w_data = wb_data;
            end else if (w_wa_hit) begin
                w_data = wa_data;
            end
        end

        assign rs_data[k*XLEN +: XLEN] = w_data;
        assign rs_busy[k] = (w_addr != '0) && r_busy[w_addr] && !w_wb_hit;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default parameters, BYPASS=1, two read ports).
// Directed scenarios plus a randomized run against an array-based reference model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                wa_we;
    logic [AW-1:0]       wa_addr;
    logic [XLEN-1:0]     wa_data;
    logic                wb_we;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [NREG-1:0]     busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        wa_we = 0; wa_addr = '0; wa_data = '0;
        wb_we = 0; wb_addr = '0; wb_data = '0;
        iss_valid = 0; iss_rd = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
    endtask

    // Advance one rising edge and apply the architectural effect of the inputs to the model.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (wa_we && wa_addr != 0) m_regs[wa_addr] = wa_data;
            if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
            if (wb_we && wb_addr != 0) m_busy[wb_addr] = 0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
        end
        #1;
    endtask

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
        if (wb_we && wb_addr == a) return wb_data;
        if (wa_we && wa_addr == a) return wa_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
        if (wb_we && wb_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [NREG-1:0] exp_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic test_reset();
        rst = 1; idle(); rs_addr = '0;
        model_clear();
        #2;
        for (int a = 0; a < NREG; a++) begin
            rs_addr[0 +: AW]  = AW'(a);
            rs_addr[AW +: AW] = AW'(NREG - 1 - a);
            #1;
            n_cmp++;
            if (rs_data !== '0 || rs_busy !== '0) begin
                n_err++;
                $display("FAIL reset_read addr=%0d got data=%h busy=%b want 0", a, rs_data, rs_busy);
            end
        end
        n_cmp++;
        if (busy_vec !== '0) begin
            n_err++;
            $display("FAIL reset_busy_vec got %h want 0", busy_vec);
        end
        step();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        wa_we = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
        rs_addr[0 +: AW] = 5; rs_addr[AW +: AW] = 6;
        #1;
        n_cmp++;
        if (rs_data[0 +: XLEN] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL bypass_same_cycle got %h want deadbeef", rs_data[0 +: XLEN]);
        end
        step();
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (rs_data[0 +: XLEN] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL bypass_stored got %h want deadbeef", rs_data[0 +: XLEN]);
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        idle();
        wa_we = 1; wa_addr = 7; wa_data = 32'h11111111;
        wb_we = 1; wb_addr = 7; wb_data = 32'h22222222;
        rs_addr[AW +: AW] = 7;
        #1;
        n_cmp++;
        if (rs_data[AW*0 + XLEN +: XLEN] !== 32'h22222222) begin
            n_err++;
            $display("FAIL dual_bypass got %h want 22222222", rs_data[XLEN +: XLEN]);
        end
        step();
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (rs_data[XLEN +: XLEN] !== 32'h22222222) begin
            n_err++;
            $display("FAIL dual_write got %h want 22222222", rs_data[XLEN +: XLEN]);
        end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        idle();
        wa_we = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
        wb_we = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
        iss_valid = 1; iss_rd = 0;
        rs_addr[0 +: AW] = 0; rs_addr[AW +: AW] = 0;
        #1;
        n_cmp++;
        if (rs_data !== '0 || rs_busy !== '0) begin
            n_err++;
            $display("FAIL reg0_same_cycle got data=%h busy=%b want 0", rs_data, rs_busy);
        end
        step();
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (rs_data[0 +: XLEN] !== '0 || busy_vec[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reg0_after got data=%h busy0=%b want 0/0", rs_data[0 +: XLEN], busy_vec[0]);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        iss_valid = 1; iss_rd = 3;
        rs_addr[0 +: AW] = 3; rs_addr[AW +: AW] = 4;
        step();
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (busy_vec !== 32'h00000008 || rs_busy !== 2'b01) begin
            n_err++;
            $display("FAIL sb_set got vec=%h rs_busy=%b want 00000008/01", busy_vec, rs_busy);
        end
        iss_valid = 1; iss_rd = 3;
        step();
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (busy_vec !== 32'h00000008) begin
            n_err++;
            $display("FAIL sb_reissue got %h want 00000008", busy_vec);
        end
        wb_we = 1; wb_addr = 3; wb_data = 32'h0000ABCD;
        #1;
        n_cmp++;
        if (rs_busy[0] !== 1'b0 || rs_data[0 +: XLEN] !== 32'h0000ABCD || busy_vec !== 32'h00000008) begin
            n_err++;
            $display("FAIL sb_wb_cycle got rs_busy=%b data=%h vec=%h want 0/0000abcd/00000008",
                     rs_busy[0], rs_data[0 +: XLEN], busy_vec);
        end
        step();
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (busy_vec !== '0 || rs_busy !== '0) begin
            n_err++;
            $display("FAIL sb_clear got vec=%h rs_busy=%b want 0", busy_vec, rs_busy);
        end
        iss_valid = 1; iss_rd = 3;
        wb_we = 1; wb_addr = 3; wb_data = 32'h00001234;
        step();
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (busy_vec !== 32'h00000008 || rs_data[0 +: XLEN] !== 32'h00001234) begin
            n_err++;
            $display("FAIL sb_set_wins got vec=%h data=%h want 00000008/00001234",
                     busy_vec, rs_data[0 +: XLEN]);
        end
        wb_we = 1; wb_addr = 3; wb_data = 32'h00001234;
        step();
        @(negedge clk);
        idle();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        idle();
        wa_we = 1; wa_addr = 9; wa_data = 32'h55;
        iss_valid = 1; iss_rd = 9;
        rs_addr[0 +: AW] = 9; rs_addr[AW +: AW] = 9;
        step();
        idle();
        #1;
        n_cmp++;
        if (rs_data[0 +: XLEN] !== 32'h55 || busy_vec !== 32'h00000200) begin
            n_err++;
            $display("FAIL pre_reset got data=%h vec=%h want 55/00000200", rs_data[0 +: XLEN], busy_vec);
        end
        rst = 1;
        model_clear();
        #1;
        n_cmp++;
        if (rs_data !== '0 || busy_vec !== '0 || rs_busy !== '0) begin
            n_err++;
            $display("FAIL async_reset got data=%h vec=%h rs_busy=%b want 0", rs_data, busy_vec, rs_busy);
        end
        @(negedge clk);
        rst = 0;
        // Write and issue already in flight when reset hits must be discarded.
        wa_we = 1; wa_addr = 10; wa_data = 32'hCAFEF00D;
        iss_valid = 1; iss_rd = 10;
        #2;
        rst = 1;
        model_clear();
        step();
        @(negedge clk);
        idle();
        rst = 0;
        rs_addr[0 +: AW] = 10;
        #1;
        n_cmp++;
        if (rs_data[0 +: XLEN] !== '0 || busy_vec !== '0) begin
            n_err++;
            $display("FAIL reset_inflight got data=%h vec=%h want 0/0", rs_data[0 +: XLEN], busy_vec);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            wa_we     = ($urandom_range(0, 3) != 0);
            wa_addr   = AW'($urandom_range(0, 11));
            wa_data   = $urandom;
            wb_we     = ($urandom_range(0, 2) == 0);
            wb_addr   = AW'($urandom_range(0, 11));
            wb_data   = $urandom;
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_rd    = AW'($urandom_range(0, 11));
            rs_addr[0 +: AW]  = AW'($urandom_range(0, 11));
            rs_addr[AW +: AW] = AW'($urandom_range(0, NREG - 1));
            #1;
            for (int k = 0; k < NRD; k++) begin
                int a;
                a = int'(rs_addr[k*AW +: AW]);
                n_cmp++;
                if (rs_data[k*XLEN +: XLEN] !== exp_data(a) || rs_busy[k] !== exp_busy(a)) begin
                    n_err++;
                    $display("FAIL rand_read cyc=%0d port=%0d addr=%0d got %h/%b want %h/%b",
                             c, k, a, rs_data[k*XLEN +: XLEN], rs_busy[k], exp_data(a), exp_busy(a));
                end
            end
            n_cmp++;
            if (busy_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL rand_busy_vec cyc=%0d got %h want %h", c, busy_vec, exp_vec());
            end
            step();
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_reg0();
        test_scoreboard();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
